// File: rtl/cdr_ctrl_pkg.sv
// Shared definitions for the CDR lock controller, its loop filter and its bench.
package cdr_ctrl_pkg;

    // Sequencer states. The encoding is visible on the state port and is
    // decoded by the DLF, so the values are fixed.
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACQ    = 2'd1,
        ST_TRACK  = 2'd2,
        ST_LOCKED = 2'd3
    } cdr_state_e;

    // gain_sel encoding seen by the DLF.
    localparam logic GAIN_ACQ = 1'b1;
    localparam logic GAIN_TRK = 1'b0;

    // Width of the good/bad window run counters.
    localparam int RUN_W = 8;

endpackage

// File: rtl/cdr_pd_window.sv
// Fixed-length observation window over the BBPD decisions: a free-running
// window counter plus up/dn accumulators. net/act include the current sample,
// so they are valid for evaluation in the win_done cycle itself.
module cdr_pd_window #(
    parameter int WIN_LOG2 = 8
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       clr,
    input  logic                       up,
    input  logic                       dn,
    output logic                       win_done,
    output logic signed [WIN_LOG2+1:0] net,
    output logic        [WIN_LOG2:0]   act
);

    logic [WIN_LOG2-1:0] w_cnt_r;
    logic [WIN_LOG2:0]   up_cnt_r;
    logic [WIN_LOG2:0]   dn_cnt_r;
    logic [WIN_LOG2:0]   up_sum_s;
    logic [WIN_LOG2:0]   dn_sum_s;
    logic                up_inc_s;
    logic                dn_inc_s;

    // Fold the current sample into the running counts; coincident up&dn is a no-op.
    always_comb begin
        up_inc_s = up & ~dn;
        dn_inc_s = dn & ~up;
        up_sum_s = up_cnt_r + {{WIN_LOG2{1'b0}}, up_inc_s};
        dn_sum_s = dn_cnt_r + {{WIN_LOG2{1'b0}}, dn_inc_s};
        net      = $signed({1'b0, up_sum_s}) - $signed({1'b0, dn_sum_s});
        act      = up_sum_s + dn_sum_s;
        win_done = (w_cnt_r == {WIN_LOG2{1'b1}}) && !clr;
    end

    // Window position and accumulators; restart after each window end or on clear.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            w_cnt_r  <= {WIN_LOG2{1'b0}};
            up_cnt_r <= {(WIN_LOG2+1){1'b0}};
            dn_cnt_r <= {(WIN_LOG2+1){1'b0}};
        end else if (clr || win_done) begin
            w_cnt_r  <= {WIN_LOG2{1'b0}};
            up_cnt_r <= {(WIN_LOG2+1){1'b0}};
            dn_cnt_r <= {(WIN_LOG2+1){1'b0}};
        end else begin
            w_cnt_r  <= w_cnt_r + WIN_LOG2'(1);
            up_cnt_r <= up_sum_s;
            dn_cnt_r <= dn_sum_s;
        end
    end

endmodule

// File: rtl/cdr_lock_controller.sv
// CDR acquisition/tracking sequencer: steps the loop filter from high-gain
// acquisition to tracking to declared lock based on per-window BBPD balance,
// freezes the filter after data-less windows and falls back on loss of lock.
module cdr_lock_controller
    import cdr_ctrl_pkg::*;
#(
    parameter int WIN_LOG2  = 8,
    parameter int NET_TH    = 8,
    parameter int ACQ_WINS  = 2,
    parameter int LOCK_WINS = 4,
    parameter int UNLOCK_TH = 32,
    parameter int LOSS_WINS = 2,
    parameter int ACT_MIN   = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       up,
    input  logic       dn,
    output logic       gain_sel,
    output logic       dlf_hold,
    output logic       locked,
    output logic       lock_lost,
    output logic [1:0] state
);

    localparam int NW = WIN_LOG2 + 2;
    localparam int AW = WIN_LOG2 + 1;

    cdr_state_e       state_r, state_nxt_s;
    logic [RUN_W-1:0] good_cnt_r, good_nxt_s, good_inc_s;
    logic [RUN_W-1:0] bad_cnt_r, bad_nxt_s, bad_inc_s;
    logic             hold_r, hold_nxt_s;
    logic             lost_r, lost_nxt_s;
    logic             gain_r, gain_nxt_s;
    logic             locked_r, locked_nxt_s;

    logic              win_clr_s;
    logic              win_done_s;
    logic signed [NW-1:0] net_s;
    logic [AW-1:0]     act_s;
    logic [NW-1:0]     mag_s;
    logic              act_ok_s;
    logic              good_s;
    logic              bad_s;

    // The window only runs while the loop is active; IDLE or en low holds it at 0.
    assign win_clr_s = (state_r == ST_IDLE) || !en;

    cdr_pd_window #(
        .WIN_LOG2 (WIN_LOG2)
    ) u_window (
        .clk      (clk),
        .rst      (rst),
        .clr      (win_clr_s),
        .up       (up),
        .dn       (dn),
        .win_done (win_done_s),
        .net      (net_s),
        .act      (act_s)
    );

    // Window classification from the completed window's balance and activity.
    always_comb begin
        mag_s    = net_s[NW-1] ? (~net_s + NW'(1)) : net_s;
        act_ok_s = (act_s >= AW'(ACT_MIN));
        good_s   = (mag_s <= NW'(NET_TH)) && act_ok_s;
        bad_s    = (mag_s > NW'(UNLOCK_TH));
    end

    // Next-state, run counters, hold/pulse and decoded outputs; en low wins over everything.
    always_comb begin
        state_nxt_s = state_r;
        good_nxt_s  = good_cnt_r;
        bad_nxt_s   = bad_cnt_r;
        hold_nxt_s  = hold_r;
        lost_nxt_s  = 1'b0;
        good_inc_s  = good_cnt_r + RUN_W'(1);
        bad_inc_s   = bad_cnt_r + RUN_W'(1);
        if (!en) begin
            state_nxt_s = ST_IDLE;
            good_nxt_s  = {RUN_W{1'b0}};
            bad_nxt_s   = {RUN_W{1'b0}};
            hold_nxt_s  = 1'b0;
        end else begin
            case (state_r)
                ST_IDLE: begin
                    state_nxt_s = ST_ACQ;
                end
                ST_ACQ: begin
                    if (win_done_s && good_s) begin
                        if (good_inc_s == RUN_W'(ACQ_WINS)) begin
                            state_nxt_s = ST_TRACK;
                            good_nxt_s  = {RUN_W{1'b0}};
                        end else begin
                            good_nxt_s  = good_inc_s;
                        end
                    end else if (win_done_s) begin
                        good_nxt_s = {RUN_W{1'b0}};
                    end else begin
                        good_nxt_s = good_cnt_r;
                    end
                end
                ST_TRACK: begin
                    if (win_done_s && good_s) begin
                        if (good_inc_s == RUN_W'(LOCK_WINS)) begin
                            state_nxt_s = ST_LOCKED;
                            good_nxt_s  = {RUN_W{1'b0}};
                            bad_nxt_s   = {RUN_W{1'b0}};
                        end else begin
                            good_nxt_s  = good_inc_s;
                        end
                    end else if (win_done_s) begin
                        good_nxt_s = {RUN_W{1'b0}};
                    end else begin
                        good_nxt_s = good_cnt_r;
                    end
                end
                ST_LOCKED: begin
                    if (win_done_s && !act_ok_s) begin
                        // Data-less window: freeze the DLF next window, leave bad run alone.
                        hold_nxt_s = 1'b1;
                    end else if (win_done_s) begin
                        hold_nxt_s = 1'b0;
                        if (bad_s && (bad_inc_s == RUN_W'(LOSS_WINS))) begin
                            state_nxt_s = ST_ACQ;
                            lost_nxt_s  = 1'b1;
                            good_nxt_s  = {RUN_W{1'b0}};
                            bad_nxt_s   = {RUN_W{1'b0}};
                        end else if (bad_s) begin
                            bad_nxt_s = bad_inc_s;
                        end else begin
                            bad_nxt_s = {RUN_W{1'b0}};
                        end
                    end else begin
                        hold_nxt_s = hold_r;
                    end
                end
                default: begin
                    state_nxt_s = ST_IDLE;
                    good_nxt_s  = {RUN_W{1'b0}};
                    bad_nxt_s   = {RUN_W{1'b0}};
                    hold_nxt_s  = 1'b0;
                end
            endcase
        end
        gain_nxt_s   = ((state_nxt_s == ST_IDLE) || (state_nxt_s == ST_ACQ)) ? GAIN_ACQ : GAIN_TRK;
        locked_nxt_s = (state_nxt_s == ST_LOCKED);
    end

    // State, counters and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            good_cnt_r <= {RUN_W{1'b0}};
            bad_cnt_r  <= {RUN_W{1'b0}};
            hold_r     <= 1'b0;
            lost_r     <= 1'b0;
            gain_r     <= GAIN_ACQ;
            locked_r   <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            good_cnt_r <= good_nxt_s;
            bad_cnt_r  <= bad_nxt_s;
            hold_r     <= hold_nxt_s;
            lost_r     <= lost_nxt_s;
            gain_r     <= gain_nxt_s;
            locked_r   <= locked_nxt_s;
        end
    end

    assign state     = state_r;
    assign gain_sel  = gain_r;
    assign dlf_hold  = hold_r;
    assign locked    = locked_r;
    assign lock_lost = lost_r;

endmodule

// File: tb/tb_cdr_lock_controller.sv
// Directed bench for cdr_lock_controller with a 16-cycle window.
module tb_cdr_lock_controller;

    logic       clk;
    logic       rst;
    logic       en;
    logic       up;
    logic       dn;
    logic       gain_sel;
    logic       dlf_hold;
    logic       locked;
    logic       lock_lost;
    logic [1:0] state;

    int n_vec;
    int n_err;
    logic alt_ph;

    localparam int M_NONE = 0;
    localparam int M_UP   = 1;
    localparam int M_ALT  = 2;
    localparam int M_BOTH = 3;

    cdr_lock_controller #(
        .WIN_LOG2  (4),
        .NET_TH    (2),
        .ACQ_WINS  (2),
        .LOCK_WINS (3),
        .UNLOCK_TH (6),
        .LOSS_WINS (2),
        .ACT_MIN   (1)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .en        (en),
        .up        (up),
        .dn        (dn),
        .gain_sel  (gain_sel),
        .dlf_hold  (dlf_hold),
        .locked    (locked),
        .lock_lost (lock_lost),
        .state     (state)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Apply n clock edges with the given up/dn pattern; returns 1 time unit after the last edge.
    task automatic tick(input int n, input int mode);
        for (int i = 0; i < n; i++) begin
            case (mode)
                M_UP:    begin up = 1'b1; dn = 1'b0; end
                M_ALT:   begin up = alt_ph; dn = ~alt_ph; alt_ph = ~alt_ph; end
                M_BOTH:  begin up = 1'b1; dn = 1'b1; end
                default: begin up = 1'b0; dn = 1'b0; end
            endcase
            @(posedge clk);
            #1;
        end
    endtask

    // Drop en for one edge, then raise it for one edge: returns just after ACQ entry.
    task automatic restart();
        en = 1'b0;
        tick(1, M_NONE);
        en = 1'b1;
        tick(1, M_NONE);
    endtask

    task automatic test_reset();
        rst = 1'b1; en = 1'b0; up = 1'b0; dn = 1'b0; alt_ph = 1'b1;
        tick(2, M_NONE);
        n_vec++;
        if ({state, gain_sel, dlf_hold, locked, lock_lost} !== 6'b00_1000) begin
            n_err++;
            $display("FAIL reset_state got st=%0d g=%b h=%b l=%b ll=%b want st=0 g=1 h=0 l=0 ll=0",
                     state, gain_sel, dlf_hold, locked, lock_lost);
        end
        rst = 1'b0;
        tick(2, M_NONE);
        n_vec++;
        if (state !== 2'd0) begin
            n_err++;
            $display("FAIL idle_hold got st=%0d want 0", state);
        end
    endtask

    task automatic test_acquire_lock();
        en = 1'b1;
        tick(1, M_NONE);
        n_vec++;
        if (state !== 2'd1 || gain_sel !== 1'b1) begin
            n_err++;
            $display("FAIL acq_entry got st=%0d g=%b want st=1 g=1", state, gain_sel);
        end
        tick(31, M_ALT);
        n_vec++;
        if (gain_sel !== 1'b1 || state !== 2'd1) begin
            n_err++;
            $display("FAIL acq_at31 got st=%0d g=%b want st=1 g=1", state, gain_sel);
        end
        tick(1, M_ALT);
        n_vec++;
        if (gain_sel !== 1'b0 || state !== 2'd2) begin
            n_err++;
            $display("FAIL track_at32 got st=%0d g=%b want st=2 g=0", state, gain_sel);
        end
        tick(47, M_ALT);
        n_vec++;
        if (locked !== 1'b0) begin
            n_err++;
            $display("FAIL lock_at79 got l=%b want 0", locked);
        end
        tick(1, M_ALT);
        n_vec++;
        if (locked !== 1'b1 || state !== 2'd3 || gain_sel !== 1'b0) begin
            n_err++;
            $display("FAIL lock_at80 got st=%0d l=%b g=%b want st=3 l=1 g=0", state, locked, gain_sel);
        end
    endtask

    task automatic test_loss_of_lock();
        tick(16, M_UP);
        n_vec++;
        if (locked !== 1'b1 || lock_lost !== 1'b0) begin
            n_err++;
            $display("FAIL one_bad got l=%b ll=%b want l=1 ll=0", locked, lock_lost);
        end
        tick(16, M_UP);
        n_vec++;
        if (lock_lost !== 1'b1 || state !== 2'd1 || gain_sel !== 1'b1 || locked !== 1'b0) begin
            n_err++;
            $display("FAIL loss got ll=%b st=%0d g=%b l=%b want ll=1 st=1 g=1 l=0",
                     lock_lost, state, gain_sel, locked);
        end
        tick(1, M_ALT);
        n_vec++;
        if (lock_lost !== 1'b0) begin
            n_err++;
            $display("FAIL loss_pulse_width got ll=%b want 0", lock_lost);
        end
        tick(79, M_ALT);
        n_vec++;
        if (locked !== 1'b1) begin
            n_err++;
            $display("FAIL relock got l=%b want 1", locked);
        end
        tick(16, M_UP);
        tick(16, M_ALT);
        tick(16, M_UP);
        n_vec++;
        if (state !== 2'd3 || locked !== 1'b1 || lock_lost !== 1'b0) begin
            n_err++;
            $display("FAIL bad_good_bad got st=%0d l=%b ll=%b want st=3 l=1 ll=0", state, locked, lock_lost);
        end
        tick(16, M_ALT);
    endtask

    task automatic test_hold();
        tick(15, M_NONE);
        n_vec++;
        if (dlf_hold !== 1'b0) begin
            n_err++;
            $display("FAIL hold_early got h=%b want 0", dlf_hold);
        end
        tick(1, M_NONE);
        n_vec++;
        if (dlf_hold !== 1'b1 || locked !== 1'b1) begin
            n_err++;
            $display("FAIL hold_set got h=%b l=%b want h=1 l=1", dlf_hold, locked);
        end
        tick(15, M_ALT);
        n_vec++;
        if (dlf_hold !== 1'b1) begin
            n_err++;
            $display("FAIL hold_window got h=%b want 1", dlf_hold);
        end
        tick(1, M_ALT);
        n_vec++;
        if (dlf_hold !== 1'b0 || locked !== 1'b1 || state !== 2'd3) begin
            n_err++;
            $display("FAIL hold_clear got h=%b l=%b st=%0d want h=0 l=1 st=3", dlf_hold, locked, state);
        end
    endtask

    task automatic test_en_drop();
        restart();
        tick(32, M_ALT);
        n_vec++;
        if (state !== 2'd2) begin
            n_err++;
            $display("FAIL track_again got st=%0d want 2", state);
        end
        tick(5, M_ALT);
        en = 1'b0;
        tick(1, M_ALT);
        n_vec++;
        if (state !== 2'd0 || gain_sel !== 1'b1 || locked !== 1'b0) begin
            n_err++;
            $display("FAIL en_drop got st=%0d g=%b l=%b want st=0 g=1 l=0", state, gain_sel, locked);
        end
        en = 1'b1;
        tick(1, M_NONE);
        tick(31, M_ALT);
        n_vec++;
        if (state !== 2'd1 || gain_sel !== 1'b1) begin
            n_err++;
            $display("FAIL win_restart got st=%0d g=%b want st=1 g=1", state, gain_sel);
        end
        tick(1, M_ALT);
        n_vec++;
        if (state !== 2'd2) begin
            n_err++;
            $display("FAIL win_restart_end got st=%0d want 2", state);
        end
    endtask

    task automatic test_always_up();
        restart();
        tick(64, M_UP);
        n_vec++;
        if (state !== 2'd1 || gain_sel !== 1'b1 || locked !== 1'b0) begin
            n_err++;
            $display("FAIL up_only got st=%0d g=%b l=%b want st=1 g=1 l=0", state, gain_sel, locked);
        end
    endtask

    task automatic test_both();
        restart();
        tick(64, M_BOTH);
        n_vec++;
        if (state !== 2'd1 || gain_sel !== 1'b1) begin
            n_err++;
            $display("FAIL both_noop got st=%0d g=%b want st=1 g=1", state, gain_sel);
        end
    endtask

    task automatic test_net_boundary();
        restart();
        // net=+2: good
        tick(2, M_UP);  alt_ph = 1'b1; tick(14, M_ALT);
        // net=+3: not good, run resets
        tick(3, M_UP);  alt_ph = 1'b1; tick(12, M_ALT); tick(1, M_NONE);
        // net=+2: good, run=1
        tick(2, M_UP);  alt_ph = 1'b1; tick(14, M_ALT);
        n_vec++;
        if (state !== 2'd1) begin
            n_err++;
            $display("FAIL net3_resets_run got st=%0d want 1", state);
        end
        tick(2, M_UP);  alt_ph = 1'b1; tick(14, M_ALT);
        n_vec++;
        if (state !== 2'd2) begin
            n_err++;
            $display("FAIL net2_good got st=%0d want 2", state);
        end
    endtask

    task automatic test_rst_async();
        restart();
        tick(80, M_ALT);
        n_vec++;
        if (locked !== 1'b1) begin
            n_err++;
            $display("FAIL lock_before_rst got l=%b want 1", locked);
        end
        tick(5, M_ALT);
        #2;
        rst = 1'b1;
        #1;
        n_vec++;
        if (locked !== 1'b0 || state !== 2'd0 || gain_sel !== 1'b1) begin
            n_err++;
            $display("FAIL async_rst got l=%b st=%0d g=%b want l=0 st=0 g=1", locked, state, gain_sel);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        tick(1, M_NONE);
        n_vec++;
        if (state !== 2'd1) begin
            n_err++;
            $display("FAIL rst_release got st=%0d want 1", state);
        end
    endtask

    initial begin
        n_vec = 0;
        n_err = 0;
        test_reset();
        test_acquire_lock();
        test_loss_of_lock();
        test_hold();
        test_en_drop();
        test_always_up();
        test_both();
        test_net_boundary();
        test_rst_async();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/cdr_lock_controller.md
# cdr_lock_controller

Acquisition/tracking sequencer for the CDR loop. It sits beside the bang-bang phase detector and digital loop filter, on the loop-filter clock. It watches the BBPD Up/Dn decisions over fixed windows and steps the loop from high-gain acquisition to low-gain tracking to a declared lock. It holds the filter during data-less windows and drops back to acquisition on loss of lock.

## Interface
- WIN_LOG2, 8: window length is 2^WIN_LOG2 clk cycles
- NET_TH, 8: max |up−dn| per window counted as a "good" window
- ACQ_WINS, 2: consecutive good windows to leave ACQ
- LOCK_WINS, 4: consecutive good windows in TRACK to declare lock
- UNLOCK_TH, 32: |up−dn| above this in LOCKED is a "bad" window
- LOSS_WINS, 2: consecutive bad windows to declare loss of lock
- ACT_MIN, 1: minimum up+dn events for a window to carry data
- clk  in  1  loop-filter clock (same as DLF clock)
- rst  in  1  asynchronous reset, active-high
- en  in  1  controller enable; low forces IDLE
- up  in  1  BBPD early decision
- dn  in  1  BBPD late decision
- gain_sel  out  1  1 = DLF acquisition (high) gain, 0 = tracking gain
- dlf_hold  out  1  freeze DLF integrator for the current window
- locked  out  1  lock declared
- lock_lost  out  1  one-cycle pulse on lock loss
- state  out  2  current FSM state (IDLE=0, ACQ=1, TRACK=2, LOCKED=3)

## Operation
- Reset values: state=IDLE, gain_sel=1, dlf_hold=0, locked=0, lock_lost=0; all counters 0.
- Window accumulator runs in ACQ/TRACK/LOCKED. It samples up/dn every clk.
  - up&!dn increments up_cnt; dn&!up increments dn_cnt.
  - up&dn together, or neither, is a no-op.
- up_cnt and dn_cnt are WIN_LOG2+1 bits wide (no overflow possible). net = up_cnt−dn_cnt, signed, WIN_LOG2+2 bits. act = up_cnt+dn_cnt.
- Window end: the cycle where w_cnt = 2^WIN_LOG2−1.
  - Evaluation includes that cycle's sample.
  - Counters restart at 0 on the next cycle.
- good = (|net| ≤ NET_TH) && (act ≥ ACT_MIN). bad = |net| > UNLOCK_TH.
- IDLE: en=1 → ACQ; window starts from 0.
- ACQ, gain_sel=1:
  - good window → good_cnt++; otherwise good_cnt=0.
  - good_cnt reaching ACQ_WINS → TRACK, good_cnt=0.
- TRACK, gain_sel=0: same good-window rule; good_cnt reaching LOCK_WINS → LOCKED.
- LOCKED, gain_sel=0, locked=1:
  - bad window → bad_cnt++; otherwise bad_cnt=0.
  - bad_cnt reaching LOSS_WINS → ACQ, lock_lost=1 for one cycle, all counts cleared.
- dlf_hold applies in LOCKED only.
  - A window with act < ACT_MIN sets dlf_hold=1 for the whole following window.
  - That window is neither good nor bad, so bad_cnt is unchanged.
  - dlf_hold clears at the next window end with act ≥ ACT_MIN, or on leaving LOCKED.
- en=0 in any state → IDLE next cycle; outputs and counters return to reset values.
- The lock_lost pulse is dropped if en falls on that same edge.

## Timing
- All outputs are registered, Moore-decoded from state plus the hold/pulse flops.
- en sampled high at edge k → state=ACQ after edge k. The first window sample is at edge k+1.
- A state change takes effect on the edge that completes the deciding window. gain_sel/locked change with it.
- Minimum time from ACQ entry to locked=1 is (ACQ_WINS+LOCK_WINS)·2^WIN_LOG2 cycles.
- rst asserts outputs to reset values immediately, with no clock edge needed. This holds mid-window and in any state.
- Release is synchronous to the next clk edge.

## Structure
- Package cdr_ctrl_pkg holds:
  - the state enum typedef (2-bit);
  - GAIN_ACQ=1 and GAIN_TRK=0;
  - the state encoding constants, shared with the DLF and the bench.
- Sub-module cdr_pd_window: window counter plus up/dn accumulators. Outputs win_done, net and act, with a synchronous clear. The top holds the FSM, good/bad counters and hold/pulse flops.

## Test plan
Bench parameters: WIN_LOG2=4, NET_TH=2, ACQ_WINS=2, LOCK_WINS=3, UNLOCK_TH=6, LOSS_WINS=2, ACT_MIN=1.
- Alternating up/dn (8/8 per window) from en rise → gain_sel falls 32 cycles after ACQ entry; locked rises at 80 cycles.
- up=1 continuously (net=16) → stays ACQ, gain_sel=1, locked=0 indefinitely.
- From LOCKED, drive up-only for 2 windows → lock_lost pulses 1 cycle, state=ACQ, gain_sel=1. Repeat with 1 bad then 1 good window → stays LOCKED.
- From LOCKED, 16 cycles of up=dn=0 → dlf_hold=1 for the next 16 cycles, locked stays 1. Alternating data then resumes → dlf_hold clears at the following window end.
- up=dn=1 every cycle in ACQ → act=0; never leaves ACQ.
- en=0 mid-window in TRACK → state=IDLE next edge, gain_sel=1; en high again restarts the full window count.
- rst pulse mid-window in LOCKED → locked=0, state=IDLE without a clk edge.
